me_mem_feeder: RTL and testbench

ME_MEM_FEEDER -- requirements
Module: me_mem_feeder

---
 rtl/me_mem_feeder_pkg.sv | 26 ++
 rtl/me_window_ram.sv | 86 ++++++++
 rtl/me_mem_feeder.sv | 157 +++++++++++++++
 tb/tb_me_mem_feeder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/me_mem_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : me_mem_feeder_pkg
// Description : Shared motion-estimation types and defaults: block sizes,
//               pixel byte type and the feeder job-state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package me_mem_feeder_pkg;

   localparam int c_MACRO_DIM   = 16;
   localparam int c_SEARCH_DIM  = 48;
   localparam int c_LOAD_CNT_W  = 12;

   typedef logic [7:0] pix_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD_CUR  = 3'd1,
      ST_LOAD_SRCH = 3'd2,
      ST_START     = 3'd3,
      ST_WAIT      = 3'd4,
      ST_RESULT    = 3'd5
   } me_state_t;

endpackage
`default_nettype wire

// File: rtl/me_window_ram.sv
`default_nettype none
// ============================================================================
// Module      : me_window_ram
// Description : Current-block and search-window byte storage with a
//               registered row-slice read port; out-of-window bytes read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module me_window_ram
   import me_mem_feeder_pkg::*;
#(
   parameter int MACRO_DIM  = c_MACRO_DIM,
   parameter int SEARCH_DIM = c_SEARCH_DIM,
   parameter int WADDR_W    = c_LOAD_CNT_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cur_we,
   input  logic                        srch_we,
   input  logic [WADDR_W-1:0]          wr_addr,
   input  logic [7:0]                  wr_data,
   input  logic                        rd_en,
   input  logic [5:0]                  rd_row,
   input  logic [5:0]                  rd_col,
   output logic [MACRO_DIM:0][7:0]     spr_out,
   output logic [MACRO_DIM-1:0][7:0]   cpr_out
);

   localparam int c_CUR_WORDS  = MACRO_DIM * MACRO_DIM;
   localparam int c_SRCH_WORDS = SEARCH_DIM * SEARCH_DIM;
   localparam int c_CUR_AW     = $clog2(c_CUR_WORDS);
   localparam int c_SRCH_AW    = $clog2(c_SRCH_WORDS);

   // Raster-ordered storage: linear index = row * edge + col.
   pix_t r_cur_mem  [c_CUR_WORDS];
   pix_t r_srch_mem [c_SRCH_WORDS];

   logic [MACRO_DIM:0][7:0]   r_spr;
   logic [MACRO_DIM-1:0][7:0] r_cpr;
   logic [MACRO_DIM:0][7:0]   w_spr;
   logic [MACRO_DIM-1:0][7:0] w_cpr;
   logic                      w_row_in_srch;
   logic                      w_row_in_cur;

   assign w_row_in_srch = ({1'b0, rd_row} < 7'(SEARCH_DIM));
   assign w_row_in_cur  = ({1'b0, rd_row} < 7'(MACRO_DIM));

   // Storage writes; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (cur_we)
         r_cur_mem[wr_addr[c_CUR_AW-1:0]] <= wr_data;
      if (srch_we)
         r_srch_mem[wr_addr[c_SRCH_AW-1:0]] <= wr_data;
   end

   // Search-row slice: column sum kept 7 bits so amt+k never wraps into range.
   for (genvar k = 0; k <= MACRO_DIM; k++) begin : g_spr
      logic [6:0]           w_col;
      logic [c_SRCH_AW-1:0] w_idx;
      assign w_col    = {1'b0, rd_col} + 7'(k);
      assign w_idx    = c_SRCH_AW'(rd_row) * c_SRCH_AW'(SEARCH_DIM) + c_SRCH_AW'(w_col);
      assign w_spr[k] = (w_row_in_srch && (w_col < 7'(SEARCH_DIM))) ? r_srch_mem[w_idx] : 8'h00;
   end

   // Current-block row: whole row is zero when the row is outside the block.
   for (genvar k = 0; k < MACRO_DIM; k++) begin : g_cpr
      logic [c_CUR_AW-1:0] w_idx;
      assign w_idx    = c_CUR_AW'(rd_row) * c_CUR_AW'(MACRO_DIM) + c_CUR_AW'(k);
      assign w_cpr[k] = w_row_in_cur ? r_cur_mem[w_idx] : 8'h00;
   end

   // Read registers hold their last value unless a read is issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_spr <= '0;
         r_cpr <= '0;
      end else if (rd_en) begin
         r_spr <= w_spr;
         r_cpr <= w_cpr;
      end
   end

   assign spr_out = r_spr;
   assign cpr_out = r_cpr;

endmodule
`default_nettype wire

// File: rtl/me_mem_feeder.sv
`default_nettype none
// ============================================================================
// Module      : me_mem_feeder
// Description : Loads a current block and search window from a byte stream,
//               starts the motion estimator, serves its row reads and hands
//               the result back through a valid/ack port.
// Revision    : 1.0 - initial release
// ============================================================================
module me_mem_feeder
   import me_mem_feeder_pkg::*;
#(
   parameter int MACRO_DIM  = c_MACRO_DIM,
   parameter int SEARCH_DIM = c_SEARCH_DIM
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        go,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [7:0]                  wr_data,
   input  logic                        en_ram,
   input  logic [5:0]                  addr,
   input  logic [5:0]                  amt,
   output logic [MACRO_DIM:0][7:0]     pixel_spr_out,
   output logic [MACRO_DIM-1:0][7:0]   pixel_cpr_out,
   output logic                        me_start,
   input  logic                        me_ready,
   input  logic                        me_done,
   input  logic [5:0]                  me_mv_x,
   input  logic [5:0]                  me_mv_y,
   input  logic [15:0]                 me_min_sad,
   output logic                        res_valid,
   input  logic                        res_ack,
   output logic [5:0]                  mv_x,
   output logic [5:0]                  mv_y,
   output logic [15:0]                 min_sad,
   output logic                        busy
);

   localparam logic [c_LOAD_CNT_W-1:0] c_CUR_LAST  = c_LOAD_CNT_W'(MACRO_DIM * MACRO_DIM - 1);
   localparam logic [c_LOAD_CNT_W-1:0] c_SRCH_LAST = c_LOAD_CNT_W'(SEARCH_DIM * SEARCH_DIM - 1);

   me_state_t                 r_state;
   me_state_t                 w_state_nxt;
   logic [c_LOAD_CNT_W-1:0]   r_load_cnt;
   logic [5:0]                r_mv_x;
   logic [5:0]                r_mv_y;
   logic [15:0]               r_min_sad;
   logic                      w_wr_fire;
   logic                      w_phase_last;
   logic                      w_capture;

   assign w_wr_fire    = wr_valid && wr_ready;
   assign w_phase_last = ((r_state == ST_LOAD_CUR)  && (r_load_cnt == c_CUR_LAST)) ||
                         ((r_state == ST_LOAD_SRCH) && (r_load_cnt == c_SRCH_LAST));

   // Job state register.
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      wr_ready    = 1'b0;
      me_start    = 1'b0;
      res_valid   = 1'b0;
      busy        = 1'b1;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (go)
               w_state_nxt = ST_LOAD_CUR;
         end
         ST_LOAD_CUR: begin
            wr_ready = 1'b1;
            if (w_wr_fire && w_phase_last)
               w_state_nxt = ST_LOAD_SRCH;
         end
         ST_LOAD_SRCH: begin
            wr_ready = 1'b1;
            if (w_wr_fire && w_phase_last)
               w_state_nxt = ST_START;
         end
         ST_START: begin
            me_start = 1'b1;
            if (me_ready)
               w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (me_done) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_RESULT;
            end
         end
         ST_RESULT: begin
            res_valid = 1'b1;
            if (res_ack)
               w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Byte counter within the current load phase; restarts at each phase.
   always_ff @(posedge clk) begin
      if (rst)
         r_load_cnt <= '0;
      else if ((r_state == ST_IDLE) && go)
         r_load_cnt <= '0;
      else if (w_wr_fire)
         r_load_cnt <= w_phase_last ? '0 : r_load_cnt + 1'b1;
   end

   // Estimator result capture on completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mv_x    <= '0;
         r_mv_y    <= '0;
         r_min_sad <= '0;
      end else if (w_capture) begin
         r_mv_x    <= me_mv_x;
         r_mv_y    <= me_mv_y;
         r_min_sad <= me_min_sad;
      end
   end

   assign mv_x    = r_mv_x;
   assign mv_y    = r_mv_y;
   assign min_sad = r_min_sad;

   me_window_ram #(
      .MACRO_DIM  (MACRO_DIM),
      .SEARCH_DIM (SEARCH_DIM),
      .WADDR_W    (c_LOAD_CNT_W)
   ) u_window_ram (
      .clk     (clk),
      .rst     (rst),
      .cur_we  (w_wr_fire && (r_state == ST_LOAD_CUR)),
      .srch_we (w_wr_fire && (r_state == ST_LOAD_SRCH)),
      .wr_addr (r_load_cnt),
      .wr_data (wr_data),
      .rd_en   (en_ram && (r_state == ST_WAIT)),
      .rd_row  (addr),
      .rd_col  (amt),
      .spr_out (pixel_spr_out),
      .cpr_out (pixel_cpr_out)
   );

endmodule
`default_nettype wire

// File: tb/tb_me_mem_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_me_mem_feeder
// Description : Self-checking bench for me_mem_feeder with a row/column
//               array model of the loaded block and search window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_me_mem_feeder;

   localparam int MD = 16;
   localparam int SD = 48;
   localparam int NBYTES = MD * MD + SD * SD;

   logic               clk = 1'b0;
   logic               rst, go, wr_valid, wr_ready, en_ram;
   logic [7:0]         wr_data;
   logic [5:0]         addr, amt;
   logic [MD:0][7:0]   pixel_spr_out;
   logic [MD-1:0][7:0] pixel_cpr_out;
   logic               me_start, me_ready, me_done, res_valid, res_ack, busy;
   logic [5:0]         me_mv_x, me_mv_y, mv_x, mv_y;
   logic [15:0]        me_min_sad, min_sad;

   int n_chk  = 0;
   int n_pass = 0;

   byte unsigned cur_m  [MD][MD];
   byte unsigned srch_m [SD][SD];
   byte unsigned stream_q [$];

   always #5 clk = ~clk;

   me_mem_feeder #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) dut (
      .clk(clk), .rst(rst), .go(go), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_data(wr_data), .en_ram(en_ram), .addr(addr), .amt(amt),
      .pixel_spr_out(pixel_spr_out), .pixel_cpr_out(pixel_cpr_out),
      .me_start(me_start), .me_ready(me_ready), .me_done(me_done),
      .me_mv_x(me_mv_x), .me_mv_y(me_mv_y), .me_min_sad(me_min_sad),
      .res_valid(res_valid), .res_ack(res_ack), .mv_x(mv_x), .mv_y(mv_y),
      .min_sad(min_sad), .busy(busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Fill model arrays and the byte stream: fixed pattern or random bytes.
   task automatic build_stream(input bit pattern);
      byte unsigned b;
      stream_q.delete();
      for (int i = 0; i < MD * MD; i++) begin
         b = pattern ? byte'(i % 256) : byte'($urandom_range(0, 255));
         cur_m[i / MD][i % MD] = b;
         stream_q.push_back(b);
      end
      for (int r = 0; r < SD; r++)
         for (int c = 0; c < SD; c++) begin
            b = pattern ? byte'((r + c) % 256) : byte'($urandom_range(0, 255));
            srch_m[r][c] = b;
            stream_q.push_back(b);
         end
   endtask

   task automatic send(input int n, input bit rnd);
      int i      = 0;
      int budget = 8 * n + 100;
      while (i < n && budget > 0) begin
         wr_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         wr_data  = stream_q[i];
         if (wr_valid && wr_ready)
            i++;
         tick;
         budget--;
      end
      wr_valid = 1'b0;
      chk("bytes_accepted", i, n);
   endtask

   function automatic logic [MD:0][7:0] exp_spr(input int a, input int m);
      logic [MD:0][7:0] v;
      for (int k = 0; k <= MD; k++)
         v[k] = (a < SD && (m + k) < SD) ? srch_m[a][m + k] : 8'h00;
      return v;
   endfunction

   function automatic logic [MD-1:0][7:0] exp_cpr(input int a);
      logic [MD-1:0][7:0] v;
      for (int k = 0; k < MD; k++)
         v[k] = (a < MD) ? cur_m[a][k] : 8'h00;
      return v;
   endfunction

   task automatic do_read(input string tag, input int a, input int m);
      en_ram = 1'b1;
      addr   = 6'(a);
      amt    = 6'(m);
      tick;
      en_ram = 1'b0;
      chk({tag, "_spr"}, pixel_spr_out, exp_spr(a, m));
      chk({tag, "_cpr"}, pixel_cpr_out, exp_cpr(a));
   endtask

   task automatic start_job;
      go = 1'b1;
      tick;
      go = 1'b0;
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      logic [5:0]  rx, ry;
      logic [15:0] rs;
      logic [MD:0][7:0] held;
      rst = 1'b1; go = 1'b0; wr_valid = 1'b0; wr_data = '0; en_ram = 1'b0;
      addr = '0; amt = '0; me_ready = 1'b0; me_done = 1'b0; res_ack = 1'b0;
      me_mv_x = '0; me_mv_y = '0; me_min_sad = '0;
      tick; tick;
      rst = 1'b0;
      tick;

      chk("rst_busy", busy, 1'b0);
      chk("rst_wr_ready", wr_ready, 1'b0);
      chk("rst_me_start", me_start, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_results", {mv_x, mv_y, min_sad}, 28'h0);
      chk("rst_spr", pixel_spr_out, '0);
      chk("rst_cpr", pixel_cpr_out, '0);

      // Completion pulse outside a job has no effect.
      me_done = 1'b1; me_mv_x = 6'd7;
      tick;
      me_done = 1'b0;
      chk("idle_done_ignored", {busy, res_valid, mv_x}, 8'h00);

      // Job 1: reference pattern, continuous stream.
      build_stream(1'b1);
      start_job;
      chk("go_wr_ready", wr_ready, 1'b1);
      chk("go_busy", busy, 1'b1);
      send(NBYTES, 1'b0);
      chk("load_end_wr_ready", wr_ready, 1'b0);
      chk("load_end_me_start", me_start, 1'b1);

      go = 1'b1; me_done = 1'b1; en_ram = 1'b1; addr = 6'd1;
      tick;
      go = 1'b0; me_done = 1'b0; en_ram = 1'b0;
      chk("start_hold", {me_start, res_valid, wr_ready}, 3'b100);
      chk("start_no_read", pixel_spr_out, '0);

      me_ready = 1'b1;
      tick;
      me_ready = 1'b0;
      chk("wait_state", {me_start, busy}, 2'b01);

      do_read("r5_10", 5, 10);
      chk("r5_10_spr0", pixel_spr_out[0], 8'd15);
      chk("r5_10_spr16", pixel_spr_out[16], 8'd31);
      chk("r5_10_cpr0", pixel_cpr_out[0], 8'd80);
      do_read("r3_40", 3, 40);
      chk("r3_40_spr7", pixel_spr_out[7], 8'd50);
      chk("r3_40_spr8", pixel_spr_out[8], 8'd0);
      do_read("r20_0", 20, 0);
      chk("r20_cpr_zero", pixel_cpr_out, '0);

      addr = 6'd7;
      tick;
      chk("no_en_hold", pixel_spr_out, exp_spr(20, 0));

      me_mv_x = 6'd3; me_mv_y = 6'd61; me_min_sad = 16'h01F4; me_done = 1'b1;
      tick;
      me_done = 1'b0; me_mv_x = 6'd9; me_mv_y = 6'd9; me_min_sad = 16'h9999;
      chk("res_valid", res_valid, 1'b1);
      chk("res_values", {mv_x, mv_y, min_sad}, {6'd3, 6'd61, 16'h01F4});
      tick; tick; tick;
      chk("res_held", {res_valid, mv_x, mv_y, min_sad}, {1'b1, 6'd3, 6'd61, 16'h01F4});
      res_ack = 1'b1;
      tick;
      res_ack = 1'b0;
      chk("ack_idle", {busy, res_valid}, 2'b00);

      // Job 2: random data, reset mid-load, then a clean reload.
      build_stream(1'b0);
      start_job;
      send(100, 1'b1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("midrst_idle", {busy, wr_ready}, 2'b00);
      chk("midrst_results", {mv_x, mv_y, min_sad}, 28'h0);
      chk("midrst_spr", pixel_spr_out, '0);
      start_job;
      chk("restart_wr_ready", wr_ready, 1'b1);
      send(NBYTES, 1'b1);
      chk("job2_me_start", me_start, 1'b1);
      me_ready = 1'b1;
      tick;
      me_ready = 1'b0;

      res_ack = 1'b1;
      tick;
      res_ack = 1'b0;
      chk("wait_ack_ignored", {busy, res_valid}, 2'b10);

      for (int i = 0; i < 20; i++)
         do_read("rand_rd", $urandom_range(0, 63), $urandom_range(0, 63));

      rx = 6'($urandom); ry = 6'($urandom); rs = 16'($urandom);
      me_mv_x = rx; me_mv_y = ry; me_min_sad = rs; me_done = 1'b1;
      en_ram = 1'b1; addr = 6'd10; amt = 6'd30;
      tick;
      me_done = 1'b0; en_ram = 1'b0;
      chk("both_spr", pixel_spr_out, exp_spr(10, 30));
      chk("both_res", {res_valid, mv_x, mv_y, min_sad}, {1'b1, rx, ry, rs});
      held = exp_spr(10, 30);
      en_ram = 1'b1; addr = 6'd2; amt = 6'd0;
      tick;
      en_ram = 1'b0;
      chk("result_no_read", pixel_spr_out, held);
      res_ack = 1'b1;
      tick;
      res_ack = 1'b0;
      chk("job2_idle", busy, 1'b0);

      // Job 3: reference pattern with a throttled stream.
      build_stream(1'b1);
      start_job;
      send(NBYTES, 1'b1);
      me_ready = 1'b1;
      tick;
      me_ready = 1'b0;
      do_read("thr5_10", 5, 10);
      chk("thr_spr0", pixel_spr_out[0], 8'd15);
      chk("thr_cpr0", pixel_cpr_out[0], 8'd80);
      do_read("thr3_40", 3, 40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
